// File: rtl/chunked_addsub.sv
// chunked_addsub: multi-cycle add/subtract unit. Operands are captured on
// start, then CHUNK bits are summed per clock through a single CHUNK-bit
// ripple stage, with the inter-chunk carry held in a register. Results
// (sum/cout/ovf) update only at the completion edge, with a one-cycle done.
module chunked_addsub #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             sub,
  input  logic             cin,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  localparam logic S_IDLE = 1'b0;
  localparam logic S_RUN  = 1'b1;

  logic             state_q, state_d;
  logic [IW-1:0]    idx_q,   idx_d;
  logic [WIDTH-1:0] a_q,     a_d;
  logic [WIDTH-1:0] b_q,     b_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] part_q,  part_d;
  logic [WIDTH-1:0] sum_q,   sum_d;
  logic             cout_q,  cout_d;
  logic             ovf_q,   ovf_d;
  logic             done_q,  done_d;

  logic [CHUNK-1:0] a_chunk;
  logic [CHUNK-1:0] b_chunk;
  logic [CHUNK:0]   chunk_res;
  logic [WIDTH-1:0] part_next;
  logic             last;

  // One CHUNK-bit ripple stage on the currently selected slice.
  always_comb begin
    a_chunk   = a_q[idx_q*CHUNK +: CHUNK];
    b_chunk   = b_q[idx_q*CHUNK +: CHUNK];
    chunk_res = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, carry_q};
    part_next = part_q;
    part_next[idx_q*CHUNK +: CHUNK] = chunk_res[CHUNK-1:0];
    last      = (idx_q == IW'(NCHUNK - 1));
  end

  // Next-state logic: capture on start in IDLE, one chunk per cycle in RUN.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    part_d  = part_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = a;
          // Subtract is a + ~b + 1: invert B here and seed the carry with 1.
          b_d     = sub ? ~b : b;
          carry_d = sub ? 1'b1 : cin;
          idx_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        part_d  = part_next;
        carry_d = chunk_res[CHUNK];
        idx_d   = last ? '0 : idx_q + 1'b1;
        if (last) begin
          sum_d   = part_next;
          cout_d  = chunk_res[CHUNK];
          ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                    (part_next[WIDTH-1] != a_q[WIDTH-1]);
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and result registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      part_q  <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      part_q  <= part_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

  assign busy = (state_q == S_RUN);
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule
